// File: rtl/dbus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dbus_bridge_pkg
// Shared types for the data-bus bridge. It holds the memory-stage request and
// response structs (dbus_*), the interconnect request and response structs
// (cbus_*), the burst length and burst type encodings, and the bridge FSM
// state enum. It also provides an alignment helper.
// -----------------------------------------------------------------------------
package dbus_bridge_pkg;

    // Request from the memory stage. A zero strobe marks a read.
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;    // log2 of the access size in bytes
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;    // raw 64-bit lane data
    } dbus_resp_t;

    // Burst length encoding is beats minus one.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } cbus_len_t;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } cbus_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        cbus_len_t   len;
        cbus_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    // The address is misaligned when it is not a multiple of the access size (2^size bytes).
    function automatic logic is_misaligned(input logic [63:0] addr, input logic [2:0] size);
        logic [63:0] mask;
        mask = (64'd1 << size) - 64'd1;
        return |(addr & mask);
    endfunction

endpackage

// File: rtl/dbus_bridge.sv
// -----------------------------------------------------------------------------
// dbus_bridge
// The bridge accepts one registered request from the memory stage. It issues
// that request as a single-beat cbus transaction, enforces a response timeout,
// and returns the result as a one-cycle data_ok pulse.
// Parameters:
//   TIMEOUT      max REQ cycles without cresp.ready&&last before abort (>=2)
//   CNT_W        width of perf_cnt
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   dreq         memory-stage request (strobe==0 -> read)
//   dresp        addr_ok (combinational in IDLE), data_ok/data (DONE)
//   creq         single-beat interconnect request, valid only in REQ
//   cresp        interconnect response, sampled only in REQ
//   err_misalign pulses with data_ok for a misaligned request
//   err_timeout  pulses with data_ok for a timed-out request
//   perf_cnt     completed error-free transactions, wraps
// -----------------------------------------------------------------------------
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  dbus_req_t        dreq,
    output dbus_resp_t       dresp,
    output cbus_req_t        creq,
    input  cbus_resp_t       cresp,
    output logic             err_misalign,
    output logic             err_timeout,
    output logic [CNT_W-1:0] perf_cnt
);

    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    bridge_state_t      state_q,  state_d;
    logic [63:0]        addr_q,   addr_d;
    logic [2:0]         size_q,   size_d;
    logic [7:0]         strobe_q, strobe_d;
    logic [63:0]        wdata_q,  wdata_d;
    logic [63:0]        rdata_q,  rdata_d;
    logic               mis_q,    mis_d;
    logic               tmo_q,    tmo_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [CNT_W-1:0]   perf_q,   perf_d;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        mis_d        = mis_q;
        tmo_d        = tmo_q;
        timer_d      = timer_q;
        perf_d       = perf_q;
        dresp        = '0;
        creq         = '0;
        err_misalign = 1'b0;
        err_timeout  = 1'b0;

        unique case (state_q)
            IDLE: begin
                dresp.addr_ok = dreq.valid;
                if (dreq.valid) begin
                    addr_d   = dreq.addr;
                    size_d   = dreq.size;
                    strobe_d = dreq.strobe;
                    wdata_d  = dreq.data;
                    rdata_d  = '0;
                    tmo_d    = 1'b0;
                    timer_d  = '0;
                    // A misaligned request goes straight to DONE and never reaches the bus.
                    mis_d    = is_misaligned(dreq.addr, dreq.size);
                    state_d  = mis_d ? DONE : REQ;
                end
            end

            REQ: begin
                creq.valid    = 1'b1;
                creq.is_write = |strobe_q;
                creq.size     = size_q;
                creq.addr     = addr_q;
                creq.strobe   = strobe_q;
                creq.data     = wdata_q;
                creq.len      = MLEN1;
                creq.burst    = FIXED;
                // Completion is tested first, so it wins over a timeout in the same cycle.
                if (cresp.ready && cresp.last) begin
                    rdata_d = (|strobe_q) ? 64'd0 : cresp.data;
                    state_d = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            DONE: begin
                dresp.data_ok = 1'b1;
                dresp.data    = rdata_q;
                err_misalign  = mis_q;
                err_timeout   = tmo_q;
                if (!(mis_q || tmo_q)) begin
                    perf_d = perf_q + CNT_W'(1);
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            tmo_q    <= 1'b0;
            timer_q  <= '0;
            perf_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            tmo_q    <= tmo_d;
            timer_q  <= timer_d;
            perf_q   <= perf_d;
        end
    end

    assign perf_cnt = perf_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dbus_bridge
// Directed and randomized transactions for dbus_bridge (TIMEOUT=8, CNT_W=2).
// The expected outcome of each transaction comes from the bridge's rules:
// alignment, timeout budget, latency and counter wrap.
// -----------------------------------------------------------------------------
module tb_dbus_bridge;
    import dbus_bridge_pkg::*;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 2;

    logic             clk = 1'b0;
    logic             reset;
    dbus_req_t        dreq;
    dbus_resp_t       dresp;
    cbus_req_t        creq;
    cbus_resp_t       cresp;
    logic             err_misalign;
    logic             err_timeout;
    logic [CNT_W-1:0] perf_cnt;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    dbus_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .dreq         (dreq),
        .dresp        (dresp),
        .creq         (creq),
        .cresp        (cresp),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .perf_cnt     (perf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. waits = number of REQ cycles before ready&&last;
    // a negative value means the bus never completes.
    task automatic txn(input string name, input logic [63:0] addr, input logic [2:0] size,
                       input logic [7:0] strobe, input logic [63:0] wdata,
                       input int waits, input logic [63:0] rdata);
        logic      mis, wr, tmo;
        int        lat, exp_req, req_seen;
        logic      ok_seen;
        logic [63:0] exp_data;
        logic [1:0]  r;
        cbus_req_t   exp_creq;

        mis = (addr % (64'd1 << size)) != 64'd0;
        wr  = strobe != 8'd0;
        tmo = !mis && (waits < 0 || waits >= int'(TIMEOUT));
        if (mis) begin
            lat = 1; exp_req = 0; exp_data = 64'd0;
        end else if (tmo) begin
            lat = int'(TIMEOUT) + 1; exp_req = int'(TIMEOUT); exp_data = 64'd0;
        end else begin
            lat = waits + 2; exp_req = waits + 1; exp_data = wr ? 64'd0 : rdata;
        end
        exp_creq = '{valid: 1'b1, is_write: wr, size: size, addr: addr, strobe: strobe,
                     data: wdata, len: MLEN1, burst: FIXED};

        @(posedge clk); #1;
        dreq = '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: wdata};
        req_seen = 0;
        ok_seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check({name, " addr_ok"}, 256'(dresp.addr_ok), 256'(k == 0));
            if (creq.valid) begin
                req_seen++;
                check({name, " creq"}, 256'(creq), 256'(exp_creq));
            end
            if (dresp.data_ok) begin
                ok_seen = 1'b1;
                check({name, " latency"}, 256'(k), 256'(lat));
                check({name, " data"}, 256'(dresp.data), 256'(exp_data));
                check({name, " err_misalign"}, 256'(err_misalign), 256'(mis));
                check({name, " err_timeout"}, 256'(err_timeout), 256'(tmo));
                break;
            end
            check({name, " err quiet"}, 256'({err_misalign, err_timeout}), 256'(0));
            if (creq.valid && req_seen == waits + 1) begin
                cresp = '{ready: 1'b1, last: 1'b1, data: rdata};
            end else begin
                r = 2'($urandom);
                // Outside REQ the bus may show anything; during waits it never completes.
                cresp = '{ready: r[0], last: r[1] & (~r[0] | ~creq.valid),
                          data: {$urandom, $urandom}};
            end
            @(posedge clk);
        end
        check({name, " data_ok seen"}, 256'(ok_seen), 256'(1));
        check({name, " bus cycles"}, 256'(req_seen), 256'(exp_req));

        @(posedge clk); #1;
        dreq  = '0;
        cresp = '0;
        if (!mis && !tmo) exp_cnt++;
        @(negedge clk);
        check({name, " single data_ok"}, 256'(dresp.data_ok), 256'(0));
        check({name, " creq idle"}, 256'(creq.valid), 256'(0));
        check({name, " perf_cnt"}, 256'(perf_cnt), 256'(exp_cnt % (1 << CNT_W)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [2:0]  s;
        logic [7:0]  st;

        reset = 1'b1;
        dreq  = '0;
        cresp = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset dresp", 256'(dresp), 256'(0));
        check("reset creq", 256'(creq), 256'(0));
        check("reset errs", 256'({err_misalign, err_timeout}), 256'(0));
        check("reset perf_cnt", 256'(perf_cnt), 256'(0));

        txn("aligned read", 64'h8000_0008, 3'd3, 8'h00, 64'h0, 0, 64'hDEAD_BEEF_0123_4567);
        txn("write waits", 64'h8000_0004, 3'd2, 8'hF0, 64'h1122_3344_0000_0000, 5, 64'hFFFF_0000_FFFF_0000);
        txn("misaligned", 64'h8000_0003, 3'd1, 8'h00, 64'h0, 0, 64'h1234);
        txn("timeout", 64'h8000_0010, 3'd3, 8'h00, 64'h0, -1, 64'h0);
        txn("after timeout", 64'h8000_0018, 3'd3, 8'h00, 64'h0, 1, 64'hCAFE_F00D_5555_AAAA);
        txn("last cycle wins", 64'h8000_0020, 3'd2, 8'h00, 64'h0, int'(TIMEOUT) - 1, 64'h0BAD_C0DE_1111_2222);
        txn("back to back", 64'h8000_0028, 3'd0, 8'h01, 64'h77, 0, 64'h9);

        // Reset during REQ abandons the transaction.
        @(posedge clk); #1;
        dreq = '{valid: 1'b1, addr: 64'h8000_0040, size: 3'd3, strobe: 8'h00, data: 64'h0};
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-reset creq.valid", 256'(creq.valid), 256'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check("post-reset creq.valid", 256'(creq.valid), 256'(0));
        check("post-reset data_ok", 256'(dresp.data_ok), 256'(0));
        check("post-reset perf_cnt", 256'(perf_cnt), 256'(0));
        check("post-reset addr_ok", 256'(dresp.addr_ok), 256'(1));
        dreq = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post-reset quiet", 256'({dresp.data_ok, creq.valid}), 256'(0));
        end

        // Four completions with a 2-bit counter wrap back to zero.
        for (int i = 0; i < 4; i++) begin
            txn("wrap", 64'h8000_0100 + 64'(i * 8), 3'd3, 8'h00, 64'h0, i, {$urandom, $urandom});
        end
        check("wrap perf_cnt", 256'(perf_cnt), 256'(0));

        for (int i = 0; i < 24; i++) begin
            s  = 3'($urandom_range(0, 3));
            a  = 64'h8000_0000 | 64'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << s) - 64'd1);
            st = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
            txn("random", a, s, st, {$urandom, $urandom}, $urandom_range(0, 9), {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
